serial_not_serializer: RTL



---
 rtl/serial_not_serializer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/serial_not_serializer.sv
`default_nettype none
// ============================================================================
// Module   : serial_not_serializer
// Purpose  : Accepts a parallel word over a valid/ready handshake and emits
//            its bitwise inverse serially, LSB first, one bit per accepted
//            downstream transfer. Feeds a bit-serial NOT-stage consumer.
// Ports    : clk        - rising-edge clock
//            rst_n      - synchronous reset, active-low
//            up_valid   - upstream word valid
//            up_ready   - block can accept a word
//            up_data    - parallel word [WIDTH-1:0]
//            down_valid - serial bit valid
//            down_ready - downstream accepts the bit
//            down_bit   - current serial bit (inverted data)
//            down_last  - marks the final bit of the frame
//            busy       - frame in progress
// Option   : SERIAL_NOT_PARITY_EN - when defined, appends one odd-parity bit
//            (1 ^ XOR of the transmitted inverted bits) after the data bits;
//            down_last then marks the parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module serial_not_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic             down_bit,
  output logic             down_last,
  output logic             busy
);

  // Frame length in bits and the index of its final bit.
`ifdef SERIAL_NOT_PARITY_EN
  localparam int FRAME_W = WIDTH + 1;
`else
  localparam int FRAME_W = WIDTH;
`endif
  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t               r_state;
  logic [FRAME_W-1:0]   r_shift;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_up_ready;
  logic                 r_down_valid;
  logic                 r_down_last;
  logic                 r_busy;

  logic [WIDTH-1:0]     w_inv;
  logic [FRAME_W-1:0]   w_load_word;
  logic                 w_accept;
  logic                 w_xfer;
  logic [CNT_W-1:0]     w_cnt_next;

  // Per-bit mux-based NOT: each data bit selects a constant 0 or 1.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_inv
      assign w_inv[i] = up_data[i] ? 1'b0 : 1'b1;
    end
  endgenerate

  // The parity bit is folded into the shift register at load time so that
  // the serial path is identical for data and parity bits.
`ifdef SERIAL_NOT_PARITY_EN
  logic w_par;
  assign w_par       = ~(^w_inv);
  assign w_load_word = {w_par, w_inv};
`else
  assign w_load_word = w_inv;
`endif

  assign w_accept   = up_valid && r_up_ready;
  assign w_xfer     = down_ready;          // only evaluated in ST_SHIFT
  assign w_cnt_next = r_cnt + c_cnt_one;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_up_ready   <= 1'b0;
      r_down_valid <= 1'b0;
      r_down_last  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shift      <= w_load_word;
            r_cnt        <= '0;
            r_state      <= ST_SHIFT;
            r_up_ready   <= 1'b0;
            r_down_valid <= 1'b1;
            r_busy       <= 1'b1;
            // Frames are at least two bits long, so bit 0 is never last.
            r_down_last  <= 1'b0;
          end else begin
            // Covers the first cycle after reset release as well.
            r_up_ready   <= 1'b1;
          end
        end

        ST_SHIFT: begin
          if (w_xfer) begin
            r_shift <= {1'b0, r_shift[FRAME_W-1:1]};
            if (r_cnt == c_last_idx) begin
              // Counter is left saturated at the final index; the next
              // load clears it. up_ready rises here, giving one idle
              // bubble before the next frame can start.
              r_state      <= ST_IDLE;
              r_up_ready   <= 1'b1;
              r_down_valid <= 1'b0;
              r_busy       <= 1'b0;
              r_down_last  <= 1'b0;
            end else begin
              r_cnt        <= w_cnt_next;
              r_down_last  <= (w_cnt_next == c_last_idx);
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign up_ready   = r_up_ready;
  assign down_valid = r_down_valid;
  assign down_bit   = r_shift[0];
  assign down_last  = r_down_last;
  assign busy       = r_busy;

endmodule
`default_nettype wire
